jtag_tap_sampled: RTL and testbench

Target-side JTAG TAP controller. It sits at the far end of the simulation JTAG link and consumes jtag_TCK/TMS/TDI/TRSTn from the host bridge. It returns jtag_TDO_data/jtag_TDO_driven to that bridge. TCK is oversampled in the system clock domain, so the whole TAP (16-state FSM, IR, IDCODE, BYPASS, optional user DR) runs on one clock.

---
 rtl/jtag_tap_pkg.sv | 51 +++++
 rtl/jtag_sync_edge.sv | 49 ++++
 rtl/jtag_tap_sampled.sv | 131 +++++++++++++
 tb/tb_jtag_tap_sampled.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encoding, instruction codes and the
// TMS-driven next-state function.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_IDLE       = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_e;

  // Codes are truncated to IR_WIDTH by the user; BYPASS is all ones at any width.
  localparam logic [7:0] INSTR_IDCODE = 8'h01;
  localparam logic [7:0] INSTR_BYPASS = 8'hFF;
  localparam logic [7:0] INSTR_USER   = 8'h10;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TAP_RESET:      tap_next = tms ? TAP_RESET     : TAP_IDLE;
      TAP_IDLE:       tap_next = tms ? TAP_SELECT_DR : TAP_IDLE;
      TAP_SELECT_DR:  tap_next = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: tap_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   tap_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   tap_next = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   tap_next = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   tap_next = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  tap_next = tms ? TAP_SELECT_DR : TAP_IDLE;
      TAP_SELECT_IR:  tap_next = tms ? TAP_RESET     : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: tap_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   tap_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   tap_next = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   tap_next = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   tap_next = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  tap_next = tms ? TAP_SELECT_DR : TAP_IDLE;
      default:        tap_next = TAP_RESET;
    endcase
  endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Two-flop pin synchronizer (jtag_sync) and a variant that also emits one-cycle
// rise/fall pulses from the synchronized level (jtag_sync_edge).
module jtag_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module jtag_sync_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic q;
  logic q_d;

  jtag_sync #(.RESET_VAL(1'b0)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (d),
    .q       (q)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q_d <= 1'b0;
    else          q_d <= q;
  end

  // Pulses are combinational off registered levels, so they last exactly one clock.
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;
endmodule

// File: rtl/jtag_tap_sampled.sv
// Oversampled JTAG TAP: FSM, IR, IDCODE and BYPASS all clocked by the system clock.
// Define JTAG_TAP_USER_DR_EN to add the USER instruction and its data register ports.
module jtag_tap_sampled
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH      = 5,
  parameter logic [31:0] IDCODE_VALUE  = 32'h10001FFF,
  parameter int          USER_DR_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     jtag_TCK,
  input  logic                     jtag_TMS,
  input  logic                     jtag_TDI,
  input  logic                     jtag_TRSTn,
  output logic                     jtag_TDO_data,
  output logic                     jtag_TDO_driven,
  output logic [3:0]               tap_state
`ifdef JTAG_TAP_USER_DR_EN
  ,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     user_dr_update
`endif
);

`ifdef JTAG_TAP_USER_DR_EN
  localparam int SR_W = (USER_DR_WIDTH > 32) ? USER_DR_WIDTH : 32;
`else
  // Without the user register the shared DR shifter only has to hold IDCODE.
  localparam int SR_W = (USER_DR_WIDTH > 0) ? 32 : 32;
`endif
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(INSTR_IDCODE);

  logic tck_rise, tck_fall, tms_s, tdi_s, trst_n_s;
  tap_state_e state;
  logic [IR_WIDTH-1:0] ir, ir_sr;
  logic [SR_W-1:0] dr_sr, dr_shifted, dr_capture;
  logic sel_idcode;

  jtag_sync_edge u_tck (.clock(clock), .reset_n(reset_n), .d(jtag_TCK), .rise(tck_rise), .fall(tck_fall));
  jtag_sync #(.RESET_VAL(1'b0)) u_tms  (.clock(clock), .reset_n(reset_n), .d(jtag_TMS),   .q(tms_s));
  jtag_sync #(.RESET_VAL(1'b0)) u_tdi  (.clock(clock), .reset_n(reset_n), .d(jtag_TDI),   .q(tdi_s));
  jtag_sync #(.RESET_VAL(1'b1)) u_trst (.clock(clock), .reset_n(reset_n), .d(jtag_TRSTn), .q(trst_n_s));

  assign tap_state  = state;
  assign sel_idcode = (ir == IR_IDCODE);
`ifdef JTAG_TAP_USER_DR_EN
  logic sel_user;
  assign sel_user = (ir == IR_WIDTH'(INSTR_USER));
`endif

  // TDI enters at the MSB of whichever register is selected; unused upper bits are don't-care.
  always_comb begin
    dr_shifted = {tdi_s, dr_sr[SR_W-1:1]};
    dr_capture = '0;
    if (sel_idcode) begin
      dr_shifted[31]   = tdi_s;
      dr_capture[31:0] = IDCODE_VALUE;
    end
`ifdef JTAG_TAP_USER_DR_EN
    else if (sel_user) begin
      dr_shifted[USER_DR_WIDTH-1]   = tdi_s;
      dr_capture[USER_DR_WIDTH-1:0] = user_dr_in;
    end
`endif
    else begin
      dr_shifted[0] = tdi_s;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= TAP_RESET;
      ir              <= IR_IDCODE;
      ir_sr           <= '0;
      dr_sr           <= '0;
      jtag_TDO_data   <= 1'b0;
      jtag_TDO_driven <= 1'b0;
`ifdef JTAG_TAP_USER_DR_EN
      user_dr_out     <= '0;
      user_dr_update  <= 1'b0;
`endif
    end else begin
`ifdef JTAG_TAP_USER_DR_EN
      user_dr_update <= 1'b0;
`endif
      if (!trst_n_s) begin
        state           <= TAP_RESET;
        ir              <= IR_IDCODE;
        jtag_TDO_driven <= 1'b0;
      end else begin
        if (state == TAP_RESET) ir <= IR_IDCODE;
        if (tck_rise) begin
          case (state)
            TAP_CAPTURE_IR: ir_sr <= IR_WIDTH'(2'b01);
            TAP_SHIFT_IR:   ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
            TAP_CAPTURE_DR: dr_sr <= dr_capture;
            TAP_SHIFT_DR:   dr_sr <= dr_shifted;
            default: ;
          endcase
          state <= tap_next(state, tms_s);
        end
        if (tck_fall) begin
          jtag_TDO_driven <= 1'b0;
          case (state)
            TAP_SHIFT_IR: begin
              jtag_TDO_data   <= ir_sr[0];
              jtag_TDO_driven <= 1'b1;
            end
            TAP_SHIFT_DR: begin
              jtag_TDO_data   <= dr_sr[0];
              jtag_TDO_driven <= 1'b1;
            end
            TAP_UPDATE_IR: ir <= ir_sr;
`ifdef JTAG_TAP_USER_DR_EN
            TAP_UPDATE_DR: begin
              if (sel_user) begin
                user_dr_out    <= dr_sr[USER_DR_WIDTH-1:0];
                user_dr_update <= 1'b1;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed bench for jtag_tap_sampled: reset, IDCODE, IR capture/BYPASS, TRSTn,
// TMS reset, minimum TCK phases, async reset and (with JTAG_TAP_USER_DR_EN) USER.
module tb_jtag_tap_sampled;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tck, tms, tdi, trst_n;
  logic       tdo, drv;
  logic [3:0] tap_state;
`ifdef JTAG_TAP_USER_DR_EN
  logic [31:0] user_dr_in, user_dr_out;
  logic        user_dr_update;
  int          upd_cnt = 0;
  always @(posedge clock) if (user_dr_update) upd_cnt++;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  jtag_tap_sampled #(
    .IR_WIDTH      (5),
    .IDCODE_VALUE  (32'h10001FFF),
    .USER_DR_WIDTH (32)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .jtag_TCK        (tck),
    .jtag_TMS        (tms),
    .jtag_TDI        (tdi),
    .jtag_TRSTn      (trst_n),
    .jtag_TDO_data   (tdo),
    .jtag_TDO_driven (drv),
    .tap_state       (tap_state)
`ifdef JTAG_TAP_USER_DR_EN
    ,
    .user_dr_in      (user_dr_in),
    .user_dr_out     (user_dr_out),
    .user_dr_update  (user_dr_update)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One TCK period: rise with TMS/TDI applied, fall, then sample TDO from that fall.
  task automatic tck_bit(input logic t_ms, input logic t_di, input int half,
                         output logic o_tdo, output logic o_drv);
    tms = t_ms;
    tdi = t_di;
    tck = 1'b1;
    repeat (half) @(posedge clock);
    #1;
    tck = 1'b0;
    repeat (half) @(posedge clock);
    #1;
    o_tdo = tdo;
    o_drv = drv;
  endtask

  task automatic tck_move(input logic t_ms, input int half);
    logic a, b;
    tck_bit(t_ms, 1'b0, half, a, b);
  endtask

  // Full IR or DR scan from Run-Test/Idle back to Run-Test/Idle; dout is LSB-first TDO.
  task automatic scan(input logic is_ir, input int n, input logic [63:0] din, input int half,
                      output logic [63:0] dout, output logic drv_all, output logic exit_drv);
    logic t, d;
    dout     = '0;
    drv_all  = 1'b1;
    exit_drv = 1'b1;
    tck_move(1'b1, half);
    if (is_ir) tck_move(1'b1, half);
    tck_move(1'b0, half);
    tck_bit(1'b0, 1'b0, half, t, d);
    dout[0] = t;
    drv_all &= d;
    for (int i = 0; i < n; i++) begin
      tck_bit(i == n - 1, din[i], half, t, d);
      if (i < n - 1) begin
        dout[i+1] = t;
        drv_all  &= d;
      end else begin
        exit_drv = d;
      end
    end
    tck_move(1'b1, half);
    tck_move(1'b0, half);
  endtask

  initial begin
    logic [63:0] dout;
    logic        da, de, t, d;
`ifdef JTAG_TAP_USER_DR_EN
    int          upd_base;
    user_dr_in = 32'h12345678;
`endif
    reset_n = 1'b0;
    tck = 1'b0; tms = 1'b0; tdi = 1'b0; trst_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_state", tap_state, 4'hF);
    chk("reset_driven", drv, 1'b0);
    chk("reset_tdo", tdo, 1'b0);
`ifdef JTAG_TAP_USER_DR_EN
    chk("reset_user_dr_out", user_dr_out, 32'h0);
`endif
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // IDCODE selected straight out of reset
    tck_move(1'b0, 4);
    chk("idle_state", tap_state, 4'hC);
    scan(1'b0, 32, 64'h0, 4, dout, da, de);
    chk("idcode_value", dout[31:0], 32'h10001FFF);
    chk("idcode_driven", da, 1'b1);
    chk("idcode_exit1_driven", de, 1'b0);
    chk("idcode_end_state", tap_state, 4'hC);

    // IR capture pattern, then BYPASS delays TDI by one TCK
    scan(1'b1, 5, 64'h1F, 4, dout, da, de);
    chk("ir_capture", dout[4:0], 5'h01);
    chk("ir_driven", da, 1'b1);
    scan(1'b0, 8, 64'hA5, 4, dout, da, de);
    chk("bypass_delay", dout[7:0], 8'h4A);

    // TRSTn mid Shift-DR
    tck_move(1'b1, 4);
    tck_move(1'b0, 4);
    tck_bit(1'b0, 1'b0, 4, t, d);
    chk("shift_dr_state", tap_state, 4'h2);
    trst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("trst_state", tap_state, 4'hF);
    chk("trst_driven", drv, 1'b0);
    @(posedge clock);
    #1;
    trst_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    tck_move(1'b0, 4);
    scan(1'b0, 32, 64'h0, 4, dout, da, de);
    chk("trst_ir_idcode", dout[31:0], 32'h10001FFF);

    // Five TMS=1 from Shift-IR
    tck_move(1'b1, 4);
    tck_move(1'b1, 4);
    tck_move(1'b0, 4);
    tck_bit(1'b0, 1'b0, 4, t, d);
    chk("shift_ir_state", tap_state, 4'hA);
    chk("shift_ir_driven", d, 1'b1);
    for (int i = 0; i < 5; i++) tck_move(1'b1, 4);
    chk("tms_reset_state", tap_state, 4'hF);

    // Minimum TCK phases of 3 clocks
    tck_move(1'b0, 3);
    scan(1'b0, 32, 64'h0, 3, dout, da, de);
    chk("fast_idcode_value", dout[31:0], 32'h10001FFF);
    chk("fast_idcode_driven", da, 1'b1);

`ifdef JTAG_TAP_USER_DR_EN
    scan(1'b1, 5, 64'h10, 4, dout, da, de);
    upd_base = upd_cnt;
    scan(1'b0, 32, 64'hDEADBEEF, 4, dout, da, de);
    chk("user_capture", dout[31:0], 32'h12345678);
    chk("user_dr_out", user_dr_out, 32'hDEADBEEF);
    chk("user_update_pulses", upd_cnt - upd_base, 1);
`endif

    // Asynchronous reset mid Shift-DR
    tck_move(1'b1, 4);
    tck_move(1'b0, 4);
    tck_bit(1'b0, 1'b0, 4, t, d);
    reset_n = 1'b0;
    #1;
    chk("async_reset_state", tap_state, 4'hF);
    chk("async_reset_driven", drv, 1'b0);
    #5;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
